// File: rtl/punc_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : punc_control_mc
// Purpose  : Multicycle PUnC LC3 control FSM with req/ack or fixed-latency memory
// Revision : 1.0
// ============================================================================
module punc_control_mc #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int MEM_LAT       = 1,
  parameter int ICNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [15:0]       ir,
  input  logic [2:0]        nzp,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_addr_sel,
  output logic              mdr_ld,
  output logic              ir_ld,
  output logic              pc_clr,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic [1:0]        pc_ld_data_sel,
  output logic              rf_w_en,
  output logic              rf_w_addr_sel,
  output logic [1:0]        rf_w_data_sel,
  output logic              rf_r0_addr_sel,
  output logic              rf_r1_addr_sel,
  output logic [1:0]        alu_sel,
  output logic              alu_src_imm,
  output logic              cc_ld,
  output logic              halted,
  output logic [ICNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_IND    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [3:0] c_OP_BR   = 4'b0000;
  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_LD   = 4'b0010;
  localparam logic [3:0] c_OP_ST   = 4'b0011;
  localparam logic [3:0] c_OP_JSR  = 4'b0100;
  localparam logic [3:0] c_OP_AND  = 4'b0101;
  localparam logic [3:0] c_OP_LDR  = 4'b0110;
  localparam logic [3:0] c_OP_STR  = 4'b0111;
  localparam logic [3:0] c_OP_NOT  = 4'b1001;
  localparam logic [3:0] c_OP_LDI  = 4'b1010;
  localparam logic [3:0] c_OP_STI  = 4'b1011;
  localparam logic [3:0] c_OP_JMP  = 4'b1100;
  localparam logic [3:0] c_OP_LEA  = 4'b1110;
  localparam logic [3:0] c_OP_TRAP = 4'b1111;

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        w_op;
  logic              w_mem_op;
  logic              w_in_req;
  logic              w_ack;
  logic              w_retire;
  logic [ICNT_W-1:0] r_icnt;
  logic              w_unused_ir;

  assign w_op        = ir[15:12];
  assign w_unused_ir = ^{ir[8:6], ir[4:0]};
  assign w_mem_op    = (w_op == c_OP_LD)  || (w_op == c_OP_LDR) || (w_op == c_OP_LDI) ||
                       (w_op == c_OP_ST)  || (w_op == c_OP_STR) || (w_op == c_OP_STI);
  assign w_in_req    = (r_state == S_FETCH) || (r_state == S_IND) ||
                       ((r_state == S_EXEC) && w_mem_op);

  generate
    if (MEM_HANDSHAKE != 0) begin : g_hs
      assign w_ack = mem_ack;
    end else begin : g_lat
      localparam logic [3:0] c_LAT_LAST = 4'(MEM_LAT - 1);
      logic [3:0] r_lat_cnt;
      logic       w_unused_ack;

      assign w_unused_ack = mem_ack;
      assign w_ack        = (r_lat_cnt == c_LAT_LAST);

      // Counter sits at zero between requests, so every request starts fresh.
      always_ff @(posedge clk) begin
        if (rst)
          r_lat_cnt <= 4'd0;
        else if (w_in_req && !w_ack)
          r_lat_cnt <= r_lat_cnt + 4'd1;
        else
          r_lat_cnt <= 4'd0;
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= S_INIT;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr_sel   = 2'b00;
    mdr_ld         = 1'b0;
    ir_ld          = 1'b0;
    pc_clr         = 1'b0;
    pc_inc         = 1'b0;
    pc_ld          = 1'b0;
    pc_ld_data_sel = 2'b00;
    rf_w_en        = 1'b0;
    rf_w_addr_sel  = 1'b0;
    rf_w_data_sel  = 2'b00;
    rf_r0_addr_sel = 1'b0;
    rf_r1_addr_sel = 1'b0;
    alu_sel        = 2'b00;
    alu_src_imm    = 1'b0;
    cc_ld          = 1'b0;
    halted         = 1'b0;
    if (!rst) begin
      case (r_state)
        S_INIT: begin
          pc_clr = 1'b1;
          w_next = S_FETCH;
        end
        S_FETCH: begin
          mem_req = 1'b1;
          if (w_ack) begin
            ir_ld  = 1'b1;
            w_next = S_DECODE;
          end
        end
        S_DECODE: begin
          pc_inc = 1'b1;
          w_next = S_EXEC;
        end
        S_EXEC: begin
          w_next = S_FETCH;
          case (w_op)
            c_OP_ADD, c_OP_AND: begin
              alu_sel     = (w_op == c_OP_AND) ? 2'b01 : 2'b00;
              alu_src_imm = ir[5];
              rf_w_en     = 1'b1;
              cc_ld       = 1'b1;
            end
            c_OP_NOT: begin
              alu_sel = 2'b10;
              rf_w_en = 1'b1;
              cc_ld   = 1'b1;
            end
            c_OP_BR: pc_ld = |(ir[11:9] & nzp);
            c_OP_JMP: begin
              pc_ld          = 1'b1;
              pc_ld_data_sel = 2'b10;
            end
            c_OP_JSR: begin
              rf_w_en        = 1'b1;
              rf_w_addr_sel  = 1'b1;
              rf_w_data_sel  = 2'b11;
              pc_ld          = 1'b1;
              pc_ld_data_sel = ir[11] ? 2'b01 : 2'b10;
            end
            c_OP_LEA: begin
              rf_w_en       = 1'b1;
              rf_w_data_sel = 2'b10;
            end
            c_OP_LD, c_OP_LDR, c_OP_LDI, c_OP_STI: begin
              mem_req      = 1'b1;
              mem_addr_sel = (w_op == c_OP_LDR) ? 2'b10 : 2'b01;
              if (w_ack) begin
                mdr_ld = 1'b1;
                w_next = ((w_op == c_OP_LDI) || (w_op == c_OP_STI)) ? S_IND : S_WB;
              end else begin
                w_next = S_EXEC;
              end
            end
            c_OP_ST, c_OP_STR: begin
              mem_req        = 1'b1;
              mem_we         = 1'b1;
              mem_addr_sel   = (w_op == c_OP_STR) ? 2'b10 : 2'b01;
              rf_r1_addr_sel = 1'b1;
              if (!w_ack)
                w_next = S_EXEC;
            end
            c_OP_TRAP: w_next = S_HALT;
            default: ;
          endcase
        end
        S_IND: begin
          // ir[12] separates STI (second access writes) from LDI (second read).
          mem_req      = 1'b1;
          mem_addr_sel = 2'b11;
          if (ir[12]) begin
            mem_we         = 1'b1;
            rf_r1_addr_sel = 1'b1;
            if (w_ack)
              w_next = S_FETCH;
          end else if (w_ack) begin
            mdr_ld = 1'b1;
            w_next = S_WB;
          end
        end
        S_WB: begin
          rf_w_en       = 1'b1;
          rf_w_data_sel = 2'b01;
          cc_ld         = 1'b1;
          w_next        = S_FETCH;
        end
        S_HALT: halted = 1'b1;
        default: w_next = S_INIT;
      endcase
    end
  end

  assign w_retire = (((r_state == S_EXEC) || (r_state == S_IND) || (r_state == S_WB)) &&
                     (w_next == S_FETCH)) ||
                    ((r_state != S_HALT) && (w_next == S_HALT));

  always_ff @(posedge clk) begin
    if (rst)
      r_icnt <= '0;
    else if (w_retire && (r_icnt != {ICNT_W{1'b1}}))
      r_icnt <= r_icnt + 1'b1;
  end

  assign instr_count = r_icnt;

endmodule
`default_nettype wire

// File: tb/tb_punc_control_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_punc_control_mc
// Purpose  : Directed bench for punc_control_mc (handshake and fixed-latency)
// Revision : 1.0
// ============================================================================
module tb_punc_control_mc;

  logic        clk = 1'b0;
  logic        rst, rst_l;
  logic [15:0] ir;
  logic [2:0]  nzp;
  logic        mem_ack;

  logic        mem_req, mem_we, mdr_ld, ir_ld, pc_clr, pc_inc, pc_ld;
  logic        rf_w_en, rf_w_addr_sel, rf_r0_addr_sel, rf_r1_addr_sel, alu_src_imm, cc_ld, halted;
  logic [1:0]  mem_addr_sel, pc_ld_data_sel, rf_w_data_sel, alu_sel;
  logic [15:0] instr_count;

  logic        mem_req_l, mem_we_l, mdr_ld_l, ir_ld_l, pc_clr_l, pc_inc_l, pc_ld_l;
  logic        rf_w_en_l, rf_w_addr_sel_l, rf_r0_addr_sel_l, rf_r1_addr_sel_l, alu_src_imm_l, cc_ld_l, halted_l;
  logic [1:0]  mem_addr_sel_l, pc_ld_data_sel_l, rf_w_data_sel_l, alu_sel_l;
  logic [15:0] instr_count_l;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  punc_control_mc #(.MEM_HANDSHAKE(1), .MEM_LAT(1), .ICNT_W(16)) dut (
    .clk(clk), .rst(rst), .ir(ir), .nzp(nzp), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .mdr_ld(mdr_ld),
    .ir_ld(ir_ld), .pc_clr(pc_clr), .pc_inc(pc_inc), .pc_ld(pc_ld),
    .pc_ld_data_sel(pc_ld_data_sel), .rf_w_en(rf_w_en), .rf_w_addr_sel(rf_w_addr_sel),
    .rf_w_data_sel(rf_w_data_sel), .rf_r0_addr_sel(rf_r0_addr_sel),
    .rf_r1_addr_sel(rf_r1_addr_sel), .alu_sel(alu_sel), .alu_src_imm(alu_src_imm),
    .cc_ld(cc_ld), .halted(halted), .instr_count(instr_count)
  );

  punc_control_mc #(.MEM_HANDSHAKE(0), .MEM_LAT(3), .ICNT_W(16)) dut_l (
    .clk(clk), .rst(rst_l), .ir(ir), .nzp(nzp), .mem_ack(mem_ack),
    .mem_req(mem_req_l), .mem_we(mem_we_l), .mem_addr_sel(mem_addr_sel_l), .mdr_ld(mdr_ld_l),
    .ir_ld(ir_ld_l), .pc_clr(pc_clr_l), .pc_inc(pc_inc_l), .pc_ld(pc_ld_l),
    .pc_ld_data_sel(pc_ld_data_sel_l), .rf_w_en(rf_w_en_l), .rf_w_addr_sel(rf_w_addr_sel_l),
    .rf_w_data_sel(rf_w_data_sel_l), .rf_r0_addr_sel(rf_r0_addr_sel_l),
    .rf_r1_addr_sel(rf_r1_addr_sel_l), .alu_sel(alu_sel_l), .alu_src_imm(alu_src_imm_l),
    .cc_ld(cc_ld_l), .halted(halted_l), .instr_count(instr_count_l)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Starts in FETCH with instant ack, ends positioned in EXEC.
  task automatic fetch(input logic [15:0] instr);
    ir      = instr;
    mem_ack = 1'b1;
    #1;
    chk("fetch_req", 32'(mem_req), 32'd1);
    chk("fetch_ir_ld", 32'(ir_ld), 32'd1);
    chk("fetch_addr", 32'(mem_addr_sel), 32'd0);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("decode_pc_inc", 32'(pc_inc), 32'd1);
    cyc();
    #1;
  endtask

  initial begin
    rst = 1'b1; rst_l = 1'b1; ir = 16'h0; nzp = 3'b000; mem_ack = 1'b0;
    repeat (2) cyc();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_pc_clr", 32'(pc_clr), 32'd0);
    chk("rst_count", 32'(instr_count), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b0;
    #1;
    chk("init_pc_clr", 32'(pc_clr), 32'd1);
    cyc();

    // ADD R1,R2,#3
    fetch(16'h12A3);
    chk("add_rf_w_en", 32'(rf_w_en), 32'd1);
    chk("add_alu_sel", 32'(alu_sel), 32'd0);
    chk("add_imm", 32'(alu_src_imm), 32'd1);
    chk("add_cc_ld", 32'(cc_ld), 32'd1);
    chk("add_count_pre", 32'(instr_count), 32'd0);
    cyc();
    chk("add_count", 32'(instr_count), 32'd1);
    chk("add_back_fetch", 32'(mem_req), 32'd1);

    // BRz taken / not taken
    nzp = 3'b010;
    fetch(16'h0405);
    chk("brz_taken_pc_ld", 32'(pc_ld), 32'd1);
    chk("brz_taken_sel", 32'(pc_ld_data_sel), 32'd0);
    cyc();
    nzp = 3'b001;
    fetch(16'h0405);
    chk("brz_not_taken", 32'(pc_ld), 32'd0);
    cyc();
    chk("br_count", 32'(instr_count), 32'd3);

    // JSR #5
    fetch(16'h4805);
    chk("jsr_rf_w_en", 32'(rf_w_en), 32'd1);
    chk("jsr_addr_r7", 32'(rf_w_addr_sel), 32'd1);
    chk("jsr_data_pc", 32'(rf_w_data_sel), 32'd3);
    chk("jsr_pc_ld", 32'(pc_ld), 32'd1);
    chk("jsr_pc_sel", 32'(pc_ld_data_sel), 32'd1);
    cyc();
    chk("jsr_count", 32'(instr_count), 32'd4);

    // LDI with ack arriving in the third cycle of each data access
    fetch(16'hA002);
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 2);
      #1;
      chk("ldi_rd1_req", 32'(mem_req), 32'd1);
      chk("ldi_rd1_addr", 32'(mem_addr_sel), 32'd1);
      chk("ldi_rd1_mdr_ld", 32'(mdr_ld), 32'(k == 2));
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 2);
      #1;
      chk("ldi_rd2_req", 32'(mem_req), 32'd1);
      chk("ldi_rd2_addr", 32'(mem_addr_sel), 32'd3);
      chk("ldi_rd2_we", 32'(mem_we), 32'd0);
      chk("ldi_rd2_mdr_ld", 32'(mdr_ld), 32'(k == 2));
      cyc();
    end
    mem_ack = 1'b0;
    #1;
    chk("ldi_wb_en", 32'(rf_w_en), 32'd1);
    chk("ldi_wb_sel", 32'(rf_w_data_sel), 32'd1);
    chk("ldi_wb_cc", 32'(cc_ld), 32'd1);
    chk("ldi_wb_count", 32'(instr_count), 32'd4);
    cyc();
    chk("ldi_fetch_req", 32'(mem_req), 32'd1);
    chk("ldi_fetch_addr", 32'(mem_addr_sel), 32'd0);
    chk("ldi_count", 32'(instr_count), 32'd5);

    // ST R2,#5
    fetch(16'h3405);
    mem_ack = 1'b1;
    #1;
    chk("st_we", 32'(mem_we), 32'd1);
    chk("st_addr", 32'(mem_addr_sel), 32'd1);
    chk("st_r1_sel", 32'(rf_r1_addr_sel), 32'd1);
    cyc();
    mem_ack = 1'b0;
    chk("st_count", 32'(instr_count), 32'd6);

    // TRAP halts permanently
    fetch(16'hF025);
    chk("trap_no_req", 32'(mem_req), 32'd0);
    cyc();
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_count", 32'(instr_count), 32'd7);
    mem_ack = 1'b1;
    repeat (3) cyc();
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(mem_req), 32'd0);
    chk("halt_count_hold", 32'(instr_count), 32'd7);

    // Reset while a FETCH request is pending
    mem_ack = 1'b0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    chk("pend_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("pend_rst_req", 32'(mem_req), 32'd0);
    chk("pend_rst_pc_clr", 32'(pc_clr), 32'd1);
    chk("pend_rst_count", 32'(instr_count), 32'd0);

    // STI on the fixed-latency instance; external ack toggles are ignored
    cyc();
    rst_l = 1'b0;
    ir    = 16'hB002;
    #1;
    chk("lat_init_pc_clr", 32'(pc_clr_l), 32'd1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k != 2);
      #1;
      chk("lat_fetch_req", 32'(mem_req_l), 32'd1);
      chk("lat_fetch_ir_ld", 32'(ir_ld_l), 32'(k == 2));
      cyc();
    end
    #1;
    chk("lat_decode", 32'(pc_inc_l), 32'd1);
    cyc();
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 0);
      #1;
      chk("lat_rd_req", 32'(mem_req_l), 32'd1);
      chk("lat_rd_addr", 32'(mem_addr_sel_l), 32'd1);
      chk("lat_rd_we", 32'(mem_we_l), 32'd0);
      chk("lat_rd_mdr_ld", 32'(mdr_ld_l), 32'(k == 2));
      cyc();
    end
    for (int k = 0; k < 3; k++) begin
      mem_ack = (k == 1);
      #1;
      chk("lat_wr_req", 32'(mem_req_l), 32'd1);
      chk("lat_wr_addr", 32'(mem_addr_sel_l), 32'd3);
      chk("lat_wr_we", 32'(mem_we_l), 32'd1);
      chk("lat_wr_r1", 32'(rf_r1_addr_sel_l), 32'd1);
      cyc();
    end
    #1;
    chk("lat_fetch_back", 32'(mem_addr_sel_l), 32'd0);
    chk("lat_fetch_back_req", 32'(mem_req_l), 32'd1);
    chk("lat_count", 32'(instr_count_l), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/punc_control_mc.md
Name: punc_control_mc

Overview:
Multicycle control FSM for the PUnC LC3 processor with variable-latency memory.
- Replaces fixed single-cycle memory timing with a req/ack handshake, or an internal fixed-latency emulation selected by parameter.
- Adds LDI/STI indirection, retired-instruction counting and a halted flag.
- Drives the existing PUnC datapath muxes and decodes `ir` from the datapath.

Parameters:
- MEM_HANDSHAKE, 1: 1 = wait for `mem_ack`; 0 = ignore `mem_ack`, internal ack after MEM_LAT cycles.
- MEM_LAT, 1: cycles per access when MEM_HANDSHAKE=0 (1..15).
- ICNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ir  in  16  instruction register contents
- nzp  in  3  datapath condition codes {N,Z,P}
- mem_ack  in  1  memory access complete; read data valid this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  request is a write
- mem_addr_sel  out  2  00 PC, 01 PC+off9, 10 BaseR+off6, 11 MDR
- mdr_ld  out  1  capture memory read data into MDR
- ir_ld  out  1  capture memory read data into IR
- pc_clr  out  1  clear PC
- pc_inc  out  1  PC <= PC+1
- pc_ld  out  1  load PC
- pc_ld_data_sel  out  2  00 PC+off9, 01 PC+off11, 10 BaseR
- rf_w_en  out  1  register file write
- rf_w_addr_sel  out  1  0 ir[11:9], 1 R7
- rf_w_data_sel  out  2  00 ALU, 01 MDR, 10 PC+off9, 11 PC
- rf_r0_addr_sel  out  1  0 ir[8:6], 1 ir[11:9]
- rf_r1_addr_sel  out  1  0 ir[2:0], 1 ir[11:9]
- alu_sel  out  2  00 ADD, 01 AND, 10 NOT, 11 PASS r0
- alu_src_imm  out  1  ALU operand B = sext(ir[4:0])
- cc_ld  out  1  update NZP from RF write data
- halted  out  1  FSM in HALT
- instr_count  out  ICNT_W  retired instructions, saturating

Behaviour:
- Reset value of all outputs: 0. Reset state is INIT. rst has priority in every state, including mid-request; `mem_req` is 0 the cycle after rst is sampled.
- States: INIT, FETCH, DECODE, EXEC, IND, WB, HALT. All outputs are a function of state, `ir`, `nzp` and the current-cycle ack.
- INIT: `pc_clr`=1; next state FETCH.
- FETCH: `mem_req`=1, addr sel 00. In the ack cycle `ir_ld`=1 and next state is DECODE; otherwise stay in FETCH.
- DECODE: `pc_inc`=1; next state EXEC.
- Ack source: with MEM_HANDSHAKE=1, ack = `mem_ack`. With MEM_HANDSHAKE=0, an internal counter clears on entry to any request state and acks in the MEM_LAT-th cycle of that request.
- Request rules: `mem_req`, `mem_we` and `mem_addr_sel` stay stable until ack. `mem_ack` outside a request is ignored.
- EXEC, by `ir[15:12]`:
  - ADD 0001 / AND 0101: `alu_sel` 00/01; `alu_src_imm`=ir[5]; `rf_w_en`; `cc_ld`; r0 sel 0, r1 sel 0.
  - NOT 1001: `alu_sel` 10; `rf_w_en`; `cc_ld`.
  - BR 0000: `pc_ld` with sel 00 iff (ir[11:9] & nzp) != 0.
  - JMP 1100: `pc_ld` with sel 10, r0 sel 0.
  - JSR 0100: `rf_w_en`, `rf_w_addr_sel`=1, `rf_w_data_sel`=11 (pre-load PC); `pc_ld` with sel 01 if ir[11]=1, else sel 10.
  - LEA 1110: `rf_w_en`, data sel 10, no `cc_ld`.
  - LD 0010 / LDR 0110: read request at addr 01 / 10; on ack `mdr_ld`, go to WB.
  - LDI 1010: read at 01; on ack `mdr_ld`, go to IND.
  - ST 0011 / STR 0111: write request (`mem_we`=1) at 01 / 10, r1 sel 1 (STR also r0 sel 0); on ack go to FETCH.
  - STI 1011: read at 01; on ack `mdr_ld`, go to IND.
  - TRAP 1111: go to HALT.
  - 1000 and 1101 (reserved): NOP.
  - Every other opcode, and every memory opcode once acked without indirection, returns to FETCH.
- IND: request at addr 11. LDI reads (on ack `mdr_ld`, go to WB). STI writes (`mem_we`, r1 sel 1; on ack go to FETCH).
- WB: `rf_w_en`, data sel 01, `cc_ld`; next state FETCH.
- HALT: `halted`=1, all other controls 0; exit only via rst.
- `instr_count`: increments by 1 on each transition into FETCH from EXEC/IND/WB, and on entry to HALT. It saturates at all-ones. Reset value 0.
- Latency with zero-wait memory (ack in first request cycle):
  - 3 cycles: ALU ops, BR, JMP, JSR, LEA, ST, STR, NOP.
  - 4 cycles: LD, LDR, STI.
  - 5 cycles: LDI.
  - Each extra wait cycle adds 1 per access.

Test Plan:
- Reset, then ADD R1,R2,#3 (`ir`=0x12A3) with immediate ack → FETCH/DECODE/EXEC in 3 cycles; EXEC shows `rf_w_en`=1, `alu_sel`=00, `alu_src_imm`=1, `cc_ld`=1; `instr_count`=1.
- BRz (`ir`=0x0405) with `nzp`=010 → `pc_ld`=1, sel 00. Same instruction with `nzp`=001 → `pc_ld`=0.
- LDI (`ir`=0xA002), MEM_HANDSHAKE=1, `mem_ack` delayed 2 cycles per access:
  - two reads: addr sel 01 then 11, `mdr_ld` on each ack;
  - WB with data sel 01;
  - total 9 cycles.
- STI, MEM_HANDSHAKE=0, MEM_LAT=3 → read at 01 for 3 cycles, then write at 11 with `mem_we` for 3 cycles; external `mem_ack` toggling has no effect.
- TRAP (`ir`=0xF025) → `halted`=1 permanently and `instr_count` incremented. Asserting rst during a pending FETCH request → `mem_req`=0 next cycle, `pc_clr`=1, count=0.
- JSR #5 (`ir`=0x4805) → same cycle: `rf_w_addr_sel`=1, data sel 11, `pc_ld` sel 01.
